// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: fetch front-end bus bundle.
// master = prefetch unit, slave = imem + decode side.
interface if_prefetch_unit_if;
   logic        start_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic        valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;

   modport master (
      input  start_i,
      input  imem_ack_i,
      input  imem_data_i,
      input  redirect_i,
      input  redirect_pc_i,
      input  stall_i,
      output imem_req_o,
      output imem_addr_o,
      output valid_o,
      output inst_o,
      output pc_o,
      output pc_plus4_o
   );

   modport slave (
      output start_i,
      output imem_ack_i,
      output imem_data_i,
      output redirect_i,
      output redirect_pc_i,
      output stall_i,
      input  imem_req_o,
      input  imem_addr_o,
      input  valid_o,
      input  inst_o,
      input  pc_o,
      input  pc_plus4_o
   );
endinterface

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: fetch PC, imem req/ack, {pc,inst} FIFO.
// Optional macro IF_PREFETCH_BYPASS_EN: empty-FIFO ack bypass.
module if_prefetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   if_prefetch_unit_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        state_q;
   logic          req_q;
   logic [31:0]   addr_q;
   logic [31:0]   fetch_pc_q;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_d;
   logic [PW-1:0] rd_ptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];

   logic          xfer;
   logic          empty;
   logic          full;
   logic          byp;
   logic          head_vld;
   logic          push;
   logic          pop;
   logic          issue;
   logic [PW:0]   occ;
   logic [PW:0]   occ_nxt;
   logic [31:0]   head_pc;
   logic [31:0]   head_inst;
   logic [31:0]   out_pc;

   // Handshake, FIFO status, push/pop and the issue decision.
   always_comb begin
      xfer  = req_q & bus.imem_ack_i;
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      occ   = {1'b0, wr_ptr_q - rd_ptr_q};
`ifdef IF_PREFETCH_BYPASS_EN
      byp   = empty & xfer & (state_q == FETCH) & ~bus.redirect_i;
`else
      byp   = 1'b0;
`endif
      head_vld  = ~empty | byp;
      head_pc   = byp ? fetch_pc_q : pc_mem_q[rd_ptr_q[AW-1:0]];
      head_inst = byp ? bus.imem_data_i
                      : inst_mem_q[rd_ptr_q[AW-1:0]];
      pop  = head_vld & ~bus.stall_i & ~bus.redirect_i & ~byp;
      push = xfer & (state_q == FETCH) & ~bus.redirect_i &
             ~(byp & ~bus.stall_i) & (~full | pop);
      occ_nxt = occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      issue   = bus.start_i & (occ_nxt < DEPTH_C);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      if (bus.redirect_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // FIFO pointers; a redirect empties the queue.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage; the request address equals fetch_pc in FETCH.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q[AW-1:0]] <= bus.imem_data_i;
      end
   end

   // Fetch FSM: owns fetch_pc and the registered req/addr.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else if (bus.redirect_i) begin
         fetch_pc_q <= bus.redirect_pc_i;
         if (req_q && !bus.imem_ack_i) begin
            state_q <= DISCARD;
         end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (issue) begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
               end
            end
            FETCH: begin
               if (xfer) begin
                  fetch_pc_q <= fetch_pc_q + 32'd4;
                  if (issue) begin
                     addr_q <= fetch_pc_q + 32'd4;
                  end else begin
                     state_q <= IDLE;
                     req_q   <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (xfer) begin
                  if (issue) begin
                     state_q <= FETCH;
                     addr_q  <= fetch_pc_q;
                  end else begin
                     state_q <= IDLE;
                     req_q   <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign out_pc          = head_vld ? head_pc : 32'h0;
   assign bus.imem_req_o  = req_q;
   assign bus.imem_addr_o = addr_q;
   assign bus.valid_o     = head_vld;
   assign bus.inst_o      = head_vld ? head_inst : 32'h0;
   assign bus.pc_o        = out_pc;
   assign bus.pc_plus4_o  = out_pc + 32'd4;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: vector table, directed corner
// sequences and random traffic against a queue model.
module tb_if_prefetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      bit          st;
      bit          sl;
      bit          ak;
      bit          req;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] pc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_prefetch_unit_if bus ();

   if_prefetch_unit #(
      .DEPTH   (DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   ent_t        mq[$];
   logic [31:0] m_fpc;
   logic [31:0] m_addr;
   bit          m_busy;
   bit          m_disc;

   bit          obs_req;
   bit          obs_valid;
   logic [31:0] obs_addr;
   logic [31:0] obs_pc;

   bit          lat_pend;
   int          lat;
   bit          st, sl, ak, rd;
   logic [31:0] rpc;
   vec_t        tbl [11];

   function automatic logic [31:0] mfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fpc    = RESET_PC;
      m_addr   = RESET_PC;
      m_busy   = 1'b0;
      m_disc   = 1'b0;
      lat_pend = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge with rst low.
   task automatic do_reset(input bit late_ack);
      rst = 1'b1;
      #1;
      chk("rst_req", 32'(bus.imem_req_o), 32'h0);
      chk("rst_valid", 32'(bus.valid_o), 32'h0);
      chk("rst_inst", bus.inst_o, 32'h0);
      chk("rst_pc", bus.pc_o, 32'h0);
      chk("rst_pc4", bus.pc_plus4_o, 32'h4);
      bus.imem_ack_i  = late_ack;
      bus.imem_data_i = 32'hDEAD_BEEF;
      bus.redirect_i  = 1'b0;
      bus.stall_i     = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      bus.imem_ack_i = 1'b0;
      rst = 1'b0;
   endtask

   // One cycle: drive, check against the model, advance it.
   task automatic cyc(input bit s, input bit t, input bit a,
                      input bit r, input logic [31:0] tgt);
      logic [31:0] d;
      bit          xfer, byp, vld, pop;
      ent_t        hd;
      d = mfn(m_addr);
      bus.start_i       = s;
      bus.stall_i       = t;
      bus.imem_ack_i    = a;
      bus.imem_data_i   = d;
      bus.redirect_i    = r;
      bus.redirect_pc_i = tgt;
      #1;
      xfer = m_busy && a;
      byp  = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
      byp = xfer && !m_disc && !r && (mq.size() == 0);
`endif
      vld = (mq.size() != 0) || byp;
      hd.pc   = 32'h0;
      hd.inst = 32'h0;
      if (byp) begin
         hd.pc   = m_addr;
         hd.inst = d;
      end else if (vld) begin
         hd = mq[0];
      end
      obs_req   = bus.imem_req_o;
      obs_valid = bus.valid_o;
      obs_addr  = bus.imem_addr_o;
      obs_pc    = bus.pc_o;
      chk("req", 32'(bus.imem_req_o), 32'(m_busy));
      if (m_busy) chk("addr", bus.imem_addr_o, m_addr);
      chk("valid", 32'(bus.valid_o), 32'(vld));
      chk("inst", bus.inst_o, hd.inst);
      chk("pc", bus.pc_o, hd.pc);
      chk("pc4", bus.pc_plus4_o, hd.pc + 32'd4);
      if (r) begin
         mq.delete();
         m_fpc = tgt;
         if (m_busy && !a) begin
            m_disc = 1'b1;
         end else begin
            m_busy = 1'b0;
            m_disc = 1'b0;
         end
      end else begin
         pop = vld && !t;
         if (pop && !byp) void'(mq.pop_front());
         if (xfer && !m_disc) begin
            if (!(byp && !t)) mq.push_back('{pc: m_addr, inst: d});
            m_fpc = m_fpc + 32'd4;
         end
         if (xfer || !m_busy) begin
            m_disc = 1'b0;
            if (s && mq.size() < DEPTH) begin
               m_busy = 1'b1;
               m_addr = m_fpc;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic run_to_valid(input string nm,
                               input logic [31:0] exp_pc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc(1'b1, 1'b0, m_busy, 1'b0, 32'h0);
         if (obs_valid) begin
            seen = 1'b1;
            chk(nm, obs_pc, exp_pc);
         end
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: valid_o never rose, wanted pc %h",
                  nm, exp_pc);
      end
   endtask

   initial begin
      bus.start_i       = 1'b0;
      bus.stall_i       = 1'b0;
      bus.imem_ack_i    = 1'b0;
      bus.imem_data_i   = 32'h0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;

      // Immediate acks, decode stalled to fill, then released.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

      @(negedge clk);
      do_reset(1'b0);

`ifndef IF_PREFETCH_BYPASS_EN
      for (int i = 0; i < 11; i++) begin
         bus.start_i     = tbl[i].st;
         bus.stall_i     = tbl[i].sl;
         bus.imem_ack_i  = tbl[i].ak;
         bus.imem_data_i = mfn(tbl[i].addr);
         bus.redirect_i  = 1'b0;
         #1;
         chk("t_req", 32'(bus.imem_req_o), 32'(tbl[i].req));
         if (tbl[i].req) chk("t_addr", bus.imem_addr_o, tbl[i].addr);
         chk("t_valid", 32'(bus.valid_o), 32'(tbl[i].vld));
         chk("t_pc", bus.pc_o, tbl[i].vld ? tbl[i].pc : 32'h0);
         chk("t_inst", bus.inst_o,
             tbl[i].vld ? mfn(tbl[i].pc) : 32'h0);
         chk("t_pc4", bus.pc_plus4_o,
             (tbl[i].vld ? tbl[i].pc : 32'h0) + 32'd4);
         @(negedge clk);
      end
      do_reset(1'b0);
`endif

      // Ack-to-valid latency.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
`ifdef IF_PREFETCH_BYPASS_EN
      chk("byp_valid", 32'(obs_valid), 32'h1);
      chk("byp_pc", obs_pc, 32'h0);
`else
      chk("lat_valid_n", 32'(obs_valid), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("lat_valid_n1", 32'(obs_valid), 32'h1);
      chk("lat_pc", obs_pc, 32'h0);
`endif

      // Redirect to 0x40 while the 0x8 request is outstanding.
      do_reset(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
      chk("s1_addr_r", obs_addr, 32'h8);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s1_hold", obs_addr, 32'h8);
      chk("s1_novalid", 32'(obs_valid), 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("s1_hold_ack", obs_addr, 32'h8);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s1_req", 32'(obs_req), 32'h1);
      chk("s1_new", obs_addr, 32'h40);
      run_to_valid("s1_first_pc", 32'h40);

      // Redirect and ack in the same cycle, FIFO non-empty.
      do_reset(1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s2_flushed", 32'(obs_valid), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s2_req", 32'(obs_req), 32'h1);
      chk("s2_addr", obs_addr, 32'h80);
      run_to_valid("s2_first_pc", 32'h80);

      // Two redirects during DISCARD: the latest wins.
      do_reset(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s3_addr", obs_addr, 32'h200);
      run_to_valid("s3_first_pc", 32'h200);

      // Reset mid-FETCH with a late ack inside reset.
      do_reset(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      do_reset(1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s4_idle", 32'(obs_req), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("s4_restart", obs_addr, RESET_PC);
      run_to_valid("s4_first_pc", RESET_PC);

      // Random traffic: variable latency, stalls, redirects.
      do_reset(1'b0);
      for (int i = 0; i < 3000; i++) begin
         st = ($urandom_range(0, 9) != 0);
         sl = ($urandom_range(0, 2) == 0);
         rd = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
         else rpc = $urandom & 32'hFFFF_FFFC;
         if (m_busy) begin
            if (!lat_pend) begin
               lat_pend = 1'b1;
               lat = $urandom_range(0, 3);
            end
            ak = (lat == 0);
            if (ak) lat_pend = 1'b0;
            else lat--;
         end else begin
            ak = ($urandom_range(0, 7) == 0);
         end
         cyc(st, sl, ak, rd, rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule
